// File: rtl/bus_xfer_seq.sv
// ==== bus_xfer_seq : shared 12-bit bus transfer sequencer (DRIVE/STROBE/HOLD); rev 1.0 ====
// ==== define XFER_QUEUE_EN to add a one-entry pending request slot ====
`default_nettype none

module bus_xfer_seq #(
  parameter int SETTLE   = 1,
  parameter int STROBE_W = 1
) (
  input  logic        CLK,
  input  logic        RESET_N,
  input  logic        req,
  input  logic [1:0]  src,
  input  logic [1:0]  dst,
  input  logic [11:0] imm,
  output logic        ready,
  output logic        busy,
  output logic        done,
  output logic        oe1,
  output logic        oe2,
  output logic        oe3,
  output logic        latch,
  output logic        latch3,
  output logic [11:0] imm_out
);

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    DRIVE  = 2'd1,
    STROBE = 2'd2,
    HOLD   = 2'd3
  } state_t;

  localparam logic [3:0] SETTLE_LD = 4'(SETTLE - 1);
  localparam logic [3:0] STROBE_LD = 4'(STROBE_W - 1);

  state_t      state, state_nxt;
  logic [3:0]  cnt, cnt_nxt;
  logic [1:0]  xsrc, xsrc_nxt;
  logic [1:0]  xdst, xdst_nxt;
  logic [11:0] ximm, ximm_nxt;
  logic        accept;
  logic        active;
  logic        busy_nxt, done_nxt;
  logic        oe1_nxt, oe2_nxt, oe3_nxt;
  logic        latch_nxt, latch3_nxt;
  logic [11:0] imm_out_nxt;

`ifdef XFER_QUEUE_EN
  logic        pend_valid, pend_valid_nxt;
  logic [1:0]  pend_src, pend_src_nxt;
  logic [1:0]  pend_dst, pend_dst_nxt;
  logic [11:0] pend_imm, pend_imm_nxt;

  assign ready = !pend_valid;
`else
  assign ready = (state == IDLE);
`endif

  assign accept = req && ready;

  always_comb begin
    state_nxt = state;
    cnt_nxt   = cnt;
    xsrc_nxt  = xsrc;
    xdst_nxt  = xdst;
    ximm_nxt  = ximm;
`ifdef XFER_QUEUE_EN
    pend_valid_nxt = pend_valid;
    pend_src_nxt   = pend_src;
    pend_dst_nxt   = pend_dst;
    pend_imm_nxt   = pend_imm;
`endif

    case (state)
      IDLE: begin
        if (accept) begin
          state_nxt = DRIVE;
          cnt_nxt   = SETTLE_LD;
          xsrc_nxt  = src;
          xdst_nxt  = dst;
          ximm_nxt  = imm;
        end
      end
      DRIVE: begin
        if (cnt == 4'd0) begin
          state_nxt = STROBE;
          cnt_nxt   = STROBE_LD;
        end else begin
          cnt_nxt = cnt - 4'd1;
        end
      end
      STROBE: begin
        if (cnt == 4'd0) begin
          state_nxt = HOLD;
          cnt_nxt   = 4'd0;
        end else begin
          cnt_nxt = cnt - 4'd1;
        end
      end
      HOLD: begin
`ifdef XFER_QUEUE_EN
        // A queued request chains straight into DRIVE; an empty slot lets a fresh req do the same.
        if (pend_valid) begin
          state_nxt      = DRIVE;
          cnt_nxt        = SETTLE_LD;
          xsrc_nxt       = pend_src;
          xdst_nxt       = pend_dst;
          ximm_nxt       = pend_imm;
          pend_valid_nxt = 1'b0;
        end else if (accept) begin
          state_nxt = DRIVE;
          cnt_nxt   = SETTLE_LD;
          xsrc_nxt  = src;
          xdst_nxt  = dst;
          ximm_nxt  = imm;
        end else begin
          state_nxt = IDLE;
        end
`else
        state_nxt = IDLE;
`endif
      end
      default: state_nxt = IDLE;
    endcase

`ifdef XFER_QUEUE_EN
    if (accept && (state == DRIVE || state == STROBE)) begin
      pend_valid_nxt = 1'b1;
      pend_src_nxt   = src;
      pend_dst_nxt   = dst;
      pend_imm_nxt   = imm;
    end
`endif

    // Outputs are registered, so they are derived from the upcoming state and transfer.
    active      = (state_nxt != IDLE);
    busy_nxt    = active;
    done_nxt    = (state == HOLD);
    oe1_nxt     = active && (xsrc_nxt == 2'd0);
    oe2_nxt     = active && (xsrc_nxt == 2'd1);
    oe3_nxt     = active && (xsrc_nxt == 2'd2);
    imm_out_nxt = (active && (xsrc_nxt == 2'd3)) ? ximm_nxt : 12'd0;
    latch_nxt   = (state_nxt == STROBE) && (xdst_nxt == 2'd0 || xdst_nxt == 2'd2);
    latch3_nxt  = (state_nxt == STROBE) && (xdst_nxt == 2'd1 || xdst_nxt == 2'd2);
  end

  always_ff @(posedge CLK or negedge RESET_N) begin
    if (!RESET_N) begin
      state   <= IDLE;
      cnt     <= 4'd0;
      xsrc    <= 2'd0;
      xdst    <= 2'd0;
      ximm    <= 12'd0;
      busy    <= 1'b0;
      done    <= 1'b0;
      oe1     <= 1'b0;
      oe2     <= 1'b0;
      oe3     <= 1'b0;
      latch   <= 1'b0;
      latch3  <= 1'b0;
      imm_out <= 12'd0;
    end else begin
      state   <= state_nxt;
      cnt     <= cnt_nxt;
      xsrc    <= xsrc_nxt;
      xdst    <= xdst_nxt;
      ximm    <= ximm_nxt;
      busy    <= busy_nxt;
      done    <= done_nxt;
      oe1     <= oe1_nxt;
      oe2     <= oe2_nxt;
      oe3     <= oe3_nxt;
      latch   <= latch_nxt;
      latch3  <= latch3_nxt;
      imm_out <= imm_out_nxt;
    end
  end

`ifdef XFER_QUEUE_EN
  always_ff @(posedge CLK or negedge RESET_N) begin
    if (!RESET_N) begin
      pend_valid <= 1'b0;
      pend_src   <= 2'd0;
      pend_dst   <= 2'd0;
      pend_imm   <= 12'd0;
    end else begin
      pend_valid <= pend_valid_nxt;
      pend_src   <= pend_src_nxt;
      pend_dst   <= pend_dst_nxt;
      pend_imm   <= pend_imm_nxt;
    end
  end
`endif

endmodule

`default_nettype wire

// File: tb/tb_bus_xfer_seq.sv
// ==== tb_bus_xfer_seq : scoreboard bench for bus_xfer_seq (default and SETTLE=3/STROBE_W=2); rev 1.0 ====
`default_nettype none
`timescale 1ns/1ps

module tb_bus_xfer_seq;

  logic CLK     = 1'b0;
  logic RESET_N = 1'b0;
  always #5 CLK = ~CLK;

  logic        req0 = 1'b0, req1 = 1'b0;
  logic [1:0]  src0 = 2'd0, src1 = 2'd0;
  logic [1:0]  dst0 = 2'd0, dst1 = 2'd0;
  logic [11:0] imm0 = 12'd0, imm1 = 12'd0;
  logic        rdy0, rdy1;
  // {busy, done, oe1, oe2, oe3, latch, latch3, imm_out[11:0]}
  logic [18:0] o0, o1;

  bus_xfer_seq u_dut0 (
    .CLK(CLK), .RESET_N(RESET_N), .req(req0), .src(src0), .dst(dst0), .imm(imm0),
    .ready(rdy0), .busy(o0[18]), .done(o0[17]), .oe1(o0[16]), .oe2(o0[15]), .oe3(o0[14]),
    .latch(o0[13]), .latch3(o0[12]), .imm_out(o0[11:0])
  );

  bus_xfer_seq #(.SETTLE(3), .STROBE_W(2)) u_dut1 (
    .CLK(CLK), .RESET_N(RESET_N), .req(req1), .src(src1), .dst(dst1), .imm(imm1),
    .ready(rdy1), .busy(o1[18]), .done(o1[17]), .oe1(o1[16]), .oe2(o1[15]), .oe3(o1[14]),
    .latch(o1[13]), .latch3(o1[12]), .imm_out(o1[11:0])
  );

  typedef struct {
    int          cyc;
    logic [18:0] v;
  } exp_t;

  exp_t q0[$];
  exp_t q1[$];

  int S [0:1] = '{1, 3};
  int W [0:1] = '{1, 2};
  int last_start [0:1] = '{-100, -100};
`ifdef XFER_QUEUE_EN
  bit deferred [0:1] = '{1'b0, 1'b0};
`endif
  int cyc  = 0;
  int nvec = 0;
  int nerr = 0;

  // Whether the block should accept a request at edge number e.
  function automatic bit rdy_model(input int id, input int e);
`ifdef XFER_QUEUE_EN
    return !(deferred[id] && last_start[id] >= e);
`else
    return e >= last_start[id] + S[id] + W[id] + 2;
`endif
  endfunction

  task automatic model_reset();
    q0.delete();
    q1.delete();
    for (int i = 0; i < 2; i++) begin
      last_start[i] = -100;
`ifdef XFER_QUEUE_EN
      deferred[i] = 1'b0;
`endif
    end
  endtask

  // Push the expected output vector for every edge of one transfer accepted at edge cyc.
  task automatic schedule(input int id, input logic [1:0] s, input logic [1:0] d, input logic [11:0] im);
    int st;
    logic [18:0] v;
    exp_t x;
    st = cyc;
`ifdef XFER_QUEUE_EN
    if (last_start[id] + S[id] + W[id] + 1 > st) st = last_start[id] + S[id] + W[id] + 1;
    deferred[id] = (st > cyc);
`endif
    last_start[id] = st;
    for (int e = st; e <= st + S[id] + W[id] + 1; e++) begin
      v = '0;
      if (e <= st + S[id] + W[id]) begin
        v[18] = 1'b1;
        v[16] = (s == 2'd0);
        v[15] = (s == 2'd1);
        v[14] = (s == 2'd2);
        if (s == 2'd3) v[11:0] = im;
        if (e >= st + S[id] && e < st + S[id] + W[id]) begin
          v[13] = (d == 2'd0 || d == 2'd2);
          v[12] = (d == 2'd1 || d == 2'd2);
        end
      end else begin
        v[17] = 1'b1;
      end
      x.cyc = e;
      x.v   = v;
      if (id == 0) q0.push_back(x);
      else         q1.push_back(x);
    end
  endtask

  task automatic check(input int id);
    logic [18:0] act, exp;
    logic        r, r_exp;
    exp = '0;
    if (id == 0) begin
      while (q0.size() > 0 && q0[0].cyc <= cyc) begin
        if (q0[0].cyc == cyc) exp = exp | q0[0].v;
        void'(q0.pop_front());
      end
      act = o0;
      r   = rdy0;
    end else begin
      while (q1.size() > 0 && q1[0].cyc <= cyc) begin
        if (q1[0].cyc == cyc) exp = exp | q1[0].v;
        void'(q1.pop_front());
      end
      act = o1;
      r   = rdy1;
    end
    r_exp = rdy_model(id, cyc + 1);

    nvec++;
    assert (act === exp) else begin
      nerr++;
      $error("FAIL dut%0d.outputs edge %0d: observed %h expected %h", id, cyc, act, exp);
    end
    nvec++;
    assert (r === r_exp) else begin
      nerr++;
      $error("FAIL dut%0d.ready edge %0d: observed %b expected %b", id, cyc, r, r_exp);
    end
    nvec++;
    assert ($onehot0(act[16:14]) === 1'b1) else begin
      nerr++;
      $error("FAIL dut%0d.oe_exclusive edge %0d: observed %b expected at most one set", id, cyc, act[16:14]);
    end
  endtask

  task automatic tick();
    bit a0, a1;
    a0 = req0 && RESET_N && rdy_model(0, cyc + 1);
    a1 = req1 && RESET_N && rdy_model(1, cyc + 1);
    @(posedge CLK);
    cyc++;
    if (a0) schedule(0, src0, dst0, imm0);
    if (a1) schedule(1, src1, dst1, imm1);
    #1;
    check(0);
    check(1);
  endtask

  initial begin
    // Reset held across edges, then released mid-cycle.
    tick();
    tick();
    RESET_N = 1'b1;
    tick();

    // Default timing on dut0 (src=0,dst=0) and long immediate transfer on dut1.
    req0 = 1'b1; src0 = 2'd0; dst0 = 2'd0;
    req1 = 1'b1; src1 = 2'd3; dst1 = 2'd2; imm1 = 12'o7777;
    tick();
    req0 = 1'b0; req1 = 1'b0;
    for (int i = 0; i < 9; i++) tick();

    // Assorted source/destination combinations, one transfer each.
    for (int p = 0; p < 4; p++) begin
      req0 = 1'b1; src0 = 2'(p);       dst0 = 2'(3 - p); imm0 = 12'($urandom);
      req1 = 1'b1; src1 = 2'((p + 1) % 4); dst1 = 2'(p); imm1 = 12'($urandom);
      tick();
      req0 = 1'b0; req1 = 1'b0;
      for (int i = 0; i < 9; i++) tick();
    end

    // Request held high continuously, with source/data changing every cycle.
    req0 = 1'b1; req1 = 1'b1;
    for (int i = 0; i < 24; i++) begin
      src0 = 2'($urandom); dst0 = 2'($urandom); imm0 = 12'($urandom);
      src1 = 2'($urandom); dst1 = 2'($urandom); imm1 = 12'($urandom);
      tick();
    end
    req0 = 1'b0; req1 = 1'b0;
    for (int i = 0; i < 20; i++) tick();

    // Short back-to-back pair then a third request (queued/ignored depending on build).
    req1 = 1'b1; src1 = 2'd2; dst1 = 2'd1;
    tick();
    src1 = 2'd0; dst1 = 2'd0;
    tick();
    src1 = 2'd1; dst1 = 2'd3;
    tick();
    req1 = 1'b0;
    for (int i = 0; i < 20; i++) tick();

    // Asynchronous reset in the middle of a dut1 STROBE phase.
    req1 = 1'b1; src1 = 2'd2; dst1 = 2'd2;
    req0 = 1'b1; src0 = 2'd1; dst0 = 2'd1;
    tick();
    src1 = 2'd3; imm1 = 12'h5a5;
    tick();
    req0 = 1'b0; req1 = 1'b0;
    tick();
    tick();
    #3;
    RESET_N = 1'b0;
    #1;
    model_reset();
    check(0);
    check(1);
    #2;
    RESET_N = 1'b1;
    tick();

    // Normal transfer after reset release using oe2.
    req0 = 1'b1; src0 = 2'd1; dst0 = 2'd0;
    req1 = 1'b1; src1 = 2'd1; dst1 = 2'd1;
    tick();
    req0 = 1'b0; req1 = 1'b0;
    for (int i = 0; i < 10; i++) tick();

    $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
    $finish;
  end

endmodule

`default_nettype wire
